// File: rtl/qmem_pkg.sv
// rtl/qmem_pkg.sv - shared state encoding and default widths for the qmem arbiter
package qmem_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } qmem_state_t;

    localparam int QAW_DEF = 22;
    localparam int QDW_DEF = 32;
    localparam int QSW_DEF = QDW_DEF / 8;

endpackage

// File: rtl/qmem_rr_pick.sv
// rtl/qmem_rr_pick.sv - combinational round-robin picker, search starts after the last winner
module qmem_rr_pick
    import qmem_pkg::*;
#(
    parameter int MN = 2
) (
    input  logic [MN-1:0] req,
    input  logic [MN-1:0] last,
    output logic [MN-1:0] gnt
);

    localparam int IW = (MN > 1) ? $clog2(MN) : 1;

    logic [IW-1:0] last_idx;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt      = '0;
        last_idx = '0;
        idx      = '0;
        found    = 1'b0;
        for (int i = 0; i < MN; i++) begin
            if (last[i]) last_idx = IW'(i);
        end
        // k = MN wraps back to the previous winner, so a lone requester always wins
        for (int k = 1; k <= MN; k++) begin
            idx = IW'((int'(last_idx) + k) % MN);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qmem_rr_arbiter.sv
// rtl/qmem_rr_arbiter.sv - round-robin arbiter sharing one qmem slave among MN masters
module qmem_rr_arbiter
    import qmem_pkg::*;
#(
    parameter int MN  = 2,
    parameter int QAW = QAW_DEF,
    parameter int QDW = QDW_DEF,
    parameter int QSW = QDW / 8,
    parameter int TMO = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [MN-1:0]       qm_cs,
    input  logic [MN-1:0]       qm_we,
    input  logic [MN*QSW-1:0]   qm_sel,
    input  logic [MN*QAW-1:0]   qm_adr,
    input  logic [MN*QDW-1:0]   qm_dat_w,
    output logic [MN*QDW-1:0]   qm_dat_r,
    output logic [MN-1:0]       qm_ack,
    output logic [MN-1:0]       qm_err,
    output logic                qs_cs,
    output logic                qs_we,
    output logic [QSW-1:0]      qs_sel,
    output logic [QAW-1:0]      qs_adr,
    output logic [QDW-1:0]      qs_dat_w,
    input  logic [QDW-1:0]      qs_dat_r,
    input  logic                qs_ack,
    input  logic                qs_err,
    output logic [MN-1:0]       ms,
    output logic                tmo
);

    localparam int           CW    = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [CW-1:0] TMO_C = CW'(TMO);

    qmem_state_t   state, state_nxt;
    logic [MN-1:0] ms_nxt;
    logic [MN-1:0] last_grant, last_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          tmo_q, tmo_nxt;
    logic [MN-1:0] gnt;
    logic          busy;
    logic          cs_g;
    logic          timeout_now;

    qmem_rr_pick #(.MN(MN)) u_pick (
        .req  (qm_cs),
        .last (last_grant),
        .gnt  (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ms         <= '0;
            last_grant <= MN'(1) << (MN - 1);
            cnt        <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            ms         <= ms_nxt;
            last_grant <= last_nxt;
            cnt        <= cnt_nxt;
            tmo_q      <= tmo_nxt;
        end
    end

    // tmo_q registers "counter reaches TMO next cycle"; a same-cycle ack or abort still overrides it
    assign busy        = (state == ST_BUSY);
    assign cs_g        = |(qm_cs & ms);
    assign timeout_now = busy & tmo_q & cs_g & ~qs_ack & ~qs_err;

    always_comb begin
        state_nxt = state;
        ms_nxt    = ms;
        last_nxt  = last_grant;
        cnt_nxt   = cnt;
        tmo_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|qm_cs) begin
                    state_nxt = ST_BUSY;
                    ms_nxt    = gnt;
                    cnt_nxt   = '0;
                end
            end
            ST_BUSY: begin
                if (qs_ack || qs_err || !cs_g || timeout_now) begin
                    state_nxt = ST_IDLE;
                    ms_nxt    = '0;
                    last_nxt  = ms;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                    tmo_nxt = (TMO != 0) && (cnt_nxt == TMO_C);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                ms_nxt    = '0;
            end
        endcase
    end

    always_comb begin
        qs_we    = 1'b0;
        qs_sel   = '0;
        qs_adr   = '0;
        qs_dat_w = '0;
        for (int i = 0; i < MN; i++) begin
            if (busy && ms[i]) begin
                qs_we    = qm_we[i];
                qs_sel   = qm_sel[i*QSW +: QSW];
                qs_adr   = qm_adr[i*QAW +: QAW];
                qs_dat_w = qm_dat_w[i*QDW +: QDW];
            end
        end
        qs_cs    = busy & cs_g & ~timeout_now;
        qm_ack   = ms & {MN{busy & cs_g & qs_ack}};
        qm_err   = ms & {MN{busy & cs_g & (qs_err | timeout_now)}};
        qm_dat_r = {MN{qs_dat_r}};
        tmo      = timeout_now;
    end

endmodule

// File: tb/tb_qmem_rr_arbiter.sv
// tb/tb_qmem_rr_arbiter.sv - directed bench for qmem_rr_arbiter with hand-computed expectations
module tb_qmem_rr_arbiter;

    localparam int MN  = 2;
    localparam int QAW = 22;
    localparam int QDW = 32;
    localparam int QSW = 4;
    localparam int TMO = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [MN-1:0]       qm_cs, qm_we;
    logic [MN*QSW-1:0]   qm_sel;
    logic [MN*QAW-1:0]   qm_adr;
    logic [MN*QDW-1:0]   qm_dat_w;
    logic [MN*QDW-1:0]   qm_dat_r;
    logic [MN-1:0]       qm_ack, qm_err;
    logic                qs_cs, qs_we;
    logic [QSW-1:0]      qs_sel;
    logic [QAW-1:0]      qs_adr;
    logic [QDW-1:0]      qs_dat_w;
    logic [QDW-1:0]      qs_dat_r;
    logic                qs_ack, qs_err;
    logic [MN-1:0]       ms;
    logic                tmo;

    int n_vec = 0;
    int n_bad = 0;

    logic [1:0] exp_seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    qmem_rr_arbiter #(.MN(MN), .QAW(QAW), .QDW(QDW), .QSW(QSW), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .qm_cs(qm_cs), .qm_we(qm_we), .qm_sel(qm_sel), .qm_adr(qm_adr),
        .qm_dat_w(qm_dat_w), .qm_dat_r(qm_dat_r), .qm_ack(qm_ack), .qm_err(qm_err),
        .qs_cs(qs_cs), .qs_we(qs_we), .qs_sel(qs_sel), .qs_adr(qs_adr),
        .qs_dat_w(qs_dat_w), .qs_dat_r(qs_dat_r), .qs_ack(qs_ack), .qs_err(qs_err),
        .ms(ms), .tmo(tmo)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        qm_cs = '0; qm_we = '0; qm_sel = '0; qm_adr = '0; qm_dat_w = '0;
        qs_dat_r = '0; qs_ack = 1'b0; qs_err = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        chk_eq("rst_ms", 64'(ms), 64'h0);
        chk_eq("rst_tmo", 64'(tmo), 64'h0);
        chk_eq("rst_qs_cs", 64'(qs_cs), 64'h0);
        rst_n = 1'b1;

        // single read from m0
        qm_cs = 2'b01; qm_sel[3:0] = 4'hF; qm_adr[21:0] = 22'h000010;
        #1;
        chk_eq("s1_arb_lat_ms", 64'(ms), 64'h0);
        chk_eq("s1_idle_qs_cs", 64'(qs_cs), 64'h0);
        chk_eq("s1_idle_qs_adr", 64'(qs_adr), 64'h0);
        tick();
        chk_eq("s1_grant_ms", 64'(ms), 64'h1);
        chk_eq("s1_qs_cs", 64'(qs_cs), 64'h1);
        chk_eq("s1_qs_adr", 64'(qs_adr), 64'h10);
        chk_eq("s1_qs_sel", 64'(qs_sel), 64'hF);
        tick();
        tick();
        qs_ack = 1'b1; qs_dat_r = 32'hDEADBEEF;
        #1;
        chk_eq("s1_ack", 64'(qm_ack), 64'h1);
        chk_eq("s1_err", 64'(qm_err), 64'h0);
        chk_eq("s1_dat_r0", 64'(qm_dat_r[31:0]), 64'hDEADBEEF);
        chk_eq("s1_dat_r1", 64'(qm_dat_r[63:32]), 64'hDEADBEEF);
        tick();
        qs_ack = 1'b0; qm_cs = '0;
        #1;
        chk_eq("s1_done_ms", 64'(ms), 64'h0);

        // both masters request continuously
        do_reset();
        qm_cs = 2'b11;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk_eq("s2_busy1_ms", 64'(ms), 64'(exp_seq[t]));
            tick();
            qs_ack = 1'b1;
            #1;
            chk_eq("s2_ack", 64'(qm_ack), 64'(exp_seq[t]));
            tick();
            qs_ack = 1'b0;
            #1;
            chk_eq("s2_idle_ms", 64'(ms), 64'h0);
        end

        // timeout: slave never answers
        do_reset();
        qm_cs = 2'b01; qm_we = 2'b01;
        tick();
        for (int b = 1; b <= 4; b++) begin
            chk_eq("s3_pre_qs_cs", 64'(qs_cs), 64'h1);
            chk_eq("s3_pre_tmo", 64'(tmo), 64'h0);
            chk_eq("s3_pre_err", 64'(qm_err), 64'h0);
            tick();
        end
        chk_eq("s3_tmo_err", 64'(qm_err), 64'h1);
        chk_eq("s3_tmo_pulse", 64'(tmo), 64'h1);
        chk_eq("s3_tmo_qs_cs", 64'(qs_cs), 64'h0);
        chk_eq("s3_tmo_ms", 64'(ms), 64'h1);
        qm_cs = '0;
        tick();
        chk_eq("s3_after_ms", 64'(ms), 64'h0);
        chk_eq("s3_after_tmo", 64'(tmo), 64'h0);

        // ack coincides with timeout
        do_reset();
        qm_cs = 2'b01;
        tick();
        repeat (4) tick();
        qs_ack = 1'b1; qs_dat_r = 32'h12345678;
        #1;
        chk_eq("s4_ack", 64'(qm_ack), 64'h1);
        chk_eq("s4_err", 64'(qm_err), 64'h0);
        chk_eq("s4_tmo", 64'(tmo), 64'h0);
        chk_eq("s4_qs_cs", 64'(qs_cs), 64'h1);
        chk_eq("s4_dat", 64'(qm_dat_r[31:0]), 64'h12345678);
        tick();
        qs_ack = 1'b0; qm_cs = '0;
        #1;
        chk_eq("s4_done_ms", 64'(ms), 64'h0);
        chk_eq("s4_done_tmo", 64'(tmo), 64'h0);

        // reset during a pending write
        do_reset();
        qm_cs = 2'b01; qm_we = 2'b01; qm_dat_w[31:0] = 32'hCAFEF00D;
        tick();
        chk_eq("s5_ms", 64'(ms), 64'h1);
        chk_eq("s5_qs_we", 64'(qs_we), 64'h1);
        chk_eq("s5_qs_dat_w", 64'(qs_dat_w), 64'hCAFEF00D);
        #2;
        rst_n = 1'b0; qs_ack = 1'b1;
        #1;
        chk_eq("s5_rst_qs_cs", 64'(qs_cs), 64'h0);
        chk_eq("s5_rst_ms", 64'(ms), 64'h0);
        chk_eq("s5_rst_ack", 64'(qm_ack), 64'h0);
        qs_ack = 1'b0;
        tick();
        qm_cs = 2'b10; qm_we = '0; qm_adr[43:22] = 22'h2ABCDE;
        rst_n = 1'b1;
        #1;
        chk_eq("s5_rel_ms", 64'(ms), 64'h0);
        tick();
        chk_eq("s5_m1_ms", 64'(ms), 64'h2);
        chk_eq("s5_m1_adr", 64'(qs_adr), 64'h2ABCDE);
        chk_eq("s5_m1_we", 64'(qs_we), 64'h0);

        // m1 aborts, late slave response is ignored
        tick();
        qm_cs = '0; qs_ack = 1'b1;
        #1;
        chk_eq("s6_abort_ack", 64'(qm_ack), 64'h0);
        chk_eq("s6_abort_qs_cs", 64'(qs_cs), 64'h0);
        tick();
        qs_err = 1'b1;
        #1;
        chk_eq("s6_idle_ms", 64'(ms), 64'h0);
        chk_eq("s6_idle_ack", 64'(qm_ack), 64'h0);
        chk_eq("s6_idle_err", 64'(qm_err), 64'h0);
        tick();
        chk_eq("s6_idle2_ms", 64'(ms), 64'h0);
        chk_eq("s6_idle2_ack", 64'(qm_ack), 64'h0);
        qs_ack = 1'b0; qs_err = 1'b0; qm_cs = 2'b11;
        tick();
        chk_eq("s6_next_grant", 64'(ms), 64'h1);
        qm_cs = '0;
        tick();
        chk_eq("s6_final_ms", 64'(ms), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
